// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note codes, octave limit and scanner FSM state type
package piano_pkg;

  localparam logic [3:0] NOTE_REST = 4'd15;
  localparam logic [3:0] NOTE_C    = 4'd0;
  localparam logic [3:0] NOTE_D    = 4'd1;
  localparam logic [3:0] NOTE_E    = 4'd2;
  localparam logic [3:0] NOTE_F    = 4'd3;
  localparam logic [3:0] NOTE_G    = 4'd4;
  localparam logic [3:0] NOTE_A    = 4'd5;
  localparam logic [3:0] NOTE_B    = 4'd6;

  localparam int OCT_MAX = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser plus counter debouncer for one raw input
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Any sample agreeing with the stable level restarts the count, so bounces reset it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piano_key_scanner.sv
// rtl/piano_key_scanner.sv - debounced key/octave scanner presenting a registered note/octave pair
module piano_key_scanner #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int OCT_DEFAULT     = 2,
  parameter int OCT_MAX         = piano_pkg::OCT_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                oct_up,
  input  logic                oct_down,
  output logic [3:0]          note,
  output logic [2:0]          octave,
  output logic                note_on,
  output logic                note_strobe
);

  import piano_pkg::*;

  logic [NUM_KEYS+1:0] raw_all;
  logic [NUM_KEYS+1:0] lvl_all;
  logic [NUM_KEYS-1:0] key_lvl;
  logic                up_lvl, down_lvl, up_prev, down_prev;
  logic                up_edge, down_edge;
  logic                cur_held;

  state_t     state, state_next;
  logic [3:0] note_next;
  logic [2:0] oct_next;
  logic       note_on_next;
  logic       strobe_next;

  assign raw_all = {oct_down, oct_up, keys};

  for (genvar g = 0; g < NUM_KEYS + 2; g++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_all[g]),
      .level(lvl_all[g])
    );
  end

  assign key_lvl   = lvl_all[NUM_KEYS-1:0];
  assign up_lvl    = lvl_all[NUM_KEYS];
  assign down_lvl  = lvl_all[NUM_KEYS+1];
  assign up_edge   = up_lvl & ~up_prev;
  assign down_edge = down_lvl & ~down_prev;

  function automatic logic [3:0] lowest(input logic [NUM_KEYS-1:0] k);
    logic [3:0] r;
    r = NOTE_REST;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) r = 4'(i);
    end
    return r;
  endfunction

  // The presented note doubles as the latched current key index.
  always_comb begin
    cur_held = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (note == 4'(i)) cur_held = key_lvl[i];
    end
  end

  always_comb begin
    state_next   = state;
    note_next    = note;
    note_on_next = note_on;
    oct_next     = octave;
    case (state)
      IDLE: begin
        if (|key_lvl) begin
          state_next   = HELD;
          note_next    = lowest(key_lvl);
          note_on_next = 1'b1;
        end
      end
      HELD: begin
        if (!cur_held) begin
          if (|key_lvl) begin
            note_next = lowest(key_lvl);
          end else begin
            state_next   = IDLE;
            note_next    = NOTE_REST;
            note_on_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (up_edge && !down_edge && octave != 3'(OCT_MAX)) begin
      oct_next = octave + 3'd1;
    end else if (down_edge && !up_edge && octave != 3'd0) begin
      oct_next = octave - 3'd1;
    end
    strobe_next = (note_next != note) || (oct_next != octave) || (note_on_next != note_on);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      note        <= NOTE_REST;
      octave      <= 3'(OCT_DEFAULT);
      note_on     <= 1'b0;
      note_strobe <= 1'b0;
      up_prev     <= 1'b0;
      down_prev   <= 1'b0;
    end else begin
      state       <= state_next;
      note        <= note_next;
      octave      <= oct_next;
      note_on     <= note_on_next;
      note_strobe <= strobe_next;
      up_prev     <= up_lvl;
      down_prev   <= down_lvl;
    end
  end

endmodule

// File: tb/tb_piano_key_scanner.sv
// tb/tb_piano_key_scanner.sv - directed self-checking bench for piano_key_scanner with 4-cycle debounce
module tb_piano_key_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] keys;
  logic       oct_up;
  logic       oct_down;
  logic [3:0] note;
  logic [2:0] octave;
  logic       note_on;
  logic       note_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int base;

  piano_key_scanner #(
    .NUM_KEYS       (7),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .OCT_DEFAULT    (2),
    .OCT_MAX        (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys       (keys),
    .oct_up     (oct_up),
    .oct_down   (oct_down),
    .note       (note),
    .octave     (octave),
    .note_on    (note_on),
    .note_strobe(note_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (note_strobe === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // press/release an octave button, checking the resulting octave after the full latency
  task automatic oct_pulse(input logic up, input int exp_oct, input string tag);
    if (up) oct_up = 1'b1; else oct_down = 1'b1;
    wait_cyc(7);
    check(tag, int'(octave), exp_oct);
    wait_cyc(1);
    oct_up   = 1'b0;
    oct_down = 1'b0;
    wait_cyc(8);
  endtask

  initial begin
    rst_n    = 1'b0;
    keys     = '0;
    oct_up   = 1'b0;
    oct_down = 1'b0;
    wait_cyc(3);
    check("rst_note", int'(note), 15);
    check("rst_octave", int'(octave), 2);
    check("rst_note_on", int'(note_on), 0);
    check("rst_strobe", int'(note_strobe), 0);
    rst_n = 1'b1;
    wait_cyc(20);
    check("idle_no_strobe", strobe_cnt, 0);
    check("idle_note", int'(note), 15);

    // single key press and release
    base = strobe_cnt;
    keys = 7'b0000100;
    wait_cyc(6);
    check("press_early_note", int'(note), 15);
    wait_cyc(1);
    check("press_note", int'(note), 2);
    check("press_note_on", int'(note_on), 1);
    check("press_strobe", int'(note_strobe), 1);
    wait_cyc(1);
    check("press_strobe_drop", int'(note_strobe), 0);
    keys = 7'b0000000;
    wait_cyc(6);
    check("release_early_note", int'(note), 2);
    wait_cyc(1);
    check("release_note", int'(note), 15);
    check("release_note_on", int'(note_on), 0);
    check("release_strobe", int'(note_strobe), 1);
    wait_cyc(10);
    check("press_release_strobes", strobe_cnt - base, 2);

    // bouncing key 1
    keys = 7'b0000010;
    wait_cyc(1);
    keys = 7'b0000000;
    wait_cyc(1);
    keys = 7'b0000010;
    wait_cyc(6);
    check("bounce_early_note", int'(note), 15);
    wait_cyc(1);
    check("bounce_note", int'(note), 1);
    keys = 7'b0000000;
    wait_cyc(10);
    check("bounce_release_note", int'(note), 15);

    // hold key 4, add key 0, release key 4
    keys = 7'b0010000;
    wait_cyc(7);
    check("hold4_note", int'(note), 4);
    base = strobe_cnt;
    keys = 7'b0010001;
    wait_cyc(10);
    check("extra_key_ignored", int'(note), 4);
    check("extra_key_no_strobe", strobe_cnt - base, 0);
    keys = 7'b0000001;
    wait_cyc(6);
    check("handover_early", int'(note), 4);
    wait_cyc(1);
    check("handover_note", int'(note), 0);
    check("handover_note_on", int'(note_on), 1);
    check("handover_strobe", int'(note_strobe), 1);
    wait_cyc(5);
    check("handover_strobes", strobe_cnt - base, 1);
    keys = 7'b0000000;
    wait_cyc(10);
    check("handover_idle", int'(note_on), 0);

    // octave up with saturation
    base = strobe_cnt;
    oct_pulse(1'b1, 3, "oct_up_3");
    oct_pulse(1'b1, 4, "oct_up_4");
    oct_pulse(1'b1, 5, "oct_up_5");
    oct_pulse(1'b1, 5, "oct_up_sat");
    check("oct_up_strobes", strobe_cnt - base, 3);
    base = strobe_cnt;
    oct_pulse(1'b0, 4, "oct_dn_4");
    oct_pulse(1'b0, 3, "oct_dn_3");
    oct_pulse(1'b0, 2, "oct_dn_2");
    oct_pulse(1'b0, 1, "oct_dn_1");
    oct_pulse(1'b0, 0, "oct_dn_0");
    oct_pulse(1'b0, 0, "oct_dn_sat_a");
    oct_pulse(1'b0, 0, "oct_dn_sat_b");
    check("oct_dn_strobes", strobe_cnt - base, 5);

    // simultaneous up/down
    oct_pulse(1'b1, 1, "oct_up_1");
    base = strobe_cnt;
    oct_up   = 1'b1;
    oct_down = 1'b1;
    wait_cyc(10);
    check("oct_both_value", int'(octave), 1);
    oct_up   = 1'b0;
    oct_down = 1'b0;
    wait_cyc(10);
    check("oct_both_strobes", strobe_cnt - base, 0);

    // asynchronous reset while HELD, then re-debounce
    keys = 7'b0001000;
    wait_cyc(7);
    check("held3_note", int'(note), 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_note", int'(note), 15);
    check("async_rst_note_on", int'(note_on), 0);
    check("async_rst_octave", int'(octave), 2);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(6);
    check("redeb_early_note", int'(note), 15);
    wait_cyc(1);
    check("redeb_note", int'(note), 3);
    check("redeb_note_on", int'(note_on), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
